// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit for the E stage.
// Holds the architectural HI/LO registers and raises busy while a
// mult/multu/div/divu is in flight; mthi/mtlo complete in one edge.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        we,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        sel_hi,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] out
);

  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_NOP6  = 3'b110,
    OP_NOP7  = 3'b111
  } op_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  op_t           op_q;
  logic [31:0]   a_q, b_q, hi_q, lo_q;

  logic          acc_start, acc_mt, done;
  logic [63:0]   prod;
  logic          a_neg, b_neg;
  logic [31:0]   ua, ub, uq, ur;
  logic [31:0]   res_hi, res_lo;
  logic          res_we;

  // Request acceptance: start wins over we, and only in IDLE.
  always_comb begin
    acc_start = (state == IDLE) && start && !op[2];
    acc_mt    = (state == IDLE) && we && !start &&
                ((op == OP_MTHI) || (op == OP_MTLO));
    done      = (state == RUN) && (cnt == CW'(1));
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (acc_start) state_nx = RUN;
      RUN:  if (done)      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Result computation from the latched operands. Signed divide is done on
  // magnitudes and re-signed, so the 0x80000000 / -1 case wraps cleanly and
  // a zero divisor never reaches the divider.
  always_comb begin
    if (op_q == OP_MULT)
      prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    else
      prod = {32'b0, a_q} * {32'b0, b_q};
    a_neg = (op_q == OP_DIV) && a_q[31];
    b_neg = (op_q == OP_DIV) && b_q[31];
    ua    = a_neg ? (32'd0 - a_q) : a_q;
    ub    = b_neg ? (32'd0 - b_q) : b_q;
    if (ub == '0) begin
      uq = '0;
      ur = '0;
    end else begin
      uq = ua / ub;
      ur = ua % ub;
    end
    res_hi = hi_q;
    res_lo = lo_q;
    res_we = 1'b0;
    case (op_q)
      OP_MULT, OP_MULTU: begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        res_we = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        res_lo = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        res_hi = a_neg ? (32'd0 - ur) : ur;
        res_we = (b_q != '0);
      end
      default: res_we = 1'b0;
    endcase
  end

  // Operand latch, cycle counter and HI/LO write-back.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= '0;
      op_q <= OP_MULT;
      a_q  <= '0;
      b_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (acc_start) begin
        op_q <= op_t'(op);
        a_q  <= A;
        b_q  <= B;
        cnt  <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (state == RUN) begin
        if (done) begin
          cnt <= '0;
          if (res_we) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
      if (acc_mt) begin
        if (op == OP_MTHI) hi_q <= A;
        else               lo_q <= A;
      end
    end
  end

  // Outputs.
  always_comb begin
    busy = (state == RUN);
    HI   = hi_q;
    LO   = lo_q;
    out  = sel_hi ? hi_q : lo_q;
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed vectors for e_mdu with hand-computed results.
module tb_e_mdu;

  logic        clk, reset, start, we, sel_hi, busy;
  logic [2:0]  op;
  logic [31:0] A, B, HI, LO, out;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .we(we),
    .A(A), .B(B), .sel_hi(sel_hi), .busy(busy), .HI(HI), .LO(LO), .out(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one multi-cycle op, scramble inputs during RUN, count busy cycles.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int unsigned n, input logic [31:0] ehi, input logic [31:0] elo,
                        input string nm, input bit inject);
    int unsigned cyc = 0;
    @(negedge clk);
    start = 1'b1; we = 1'b0; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
    while (busy && cyc < 200) begin
      cyc++;
      sel_hi = cyc[0];
      #1 chk({nm, " out old"}, out, sel_hi ? hi_m : lo_m);
      A = $urandom; B = $urandom; op = 3'($urandom_range(0, 7));
      start = 1'b0; we = 1'b0;
      if (inject && cyc == 1) begin
        start = 1'b1; op = 3'b010;
      end
      if (inject && cyc == 2) begin
        we = 1'b1; op = 3'b100; A = 32'hDEAD;
      end
      @(negedge clk);
    end
    start = 1'b0; we = 1'b0;
    chk({nm, " busy cycles"}, cyc, n);
    hi_m = ehi; lo_m = elo;
    chk({nm, " HI"}, HI, ehi);
    chk({nm, " LO"}, LO, elo);
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] a);
    @(negedge clk);
    we = 1'b1; op = o; A = a;
    @(negedge clk);
    we = 1'b0;
    if (o == 3'b100) hi_m = a; else lo_m = a;
    chk("mt busy", {31'b0, busy}, 32'd0);
    chk("mt HI", HI, hi_m);
    chk("mt LO", LO, lo_m);
  endtask

  initial begin
    vecs[0] = '{3'b000, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{3'b001, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA};
    vecs[2] = '{3'b010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{3'b011, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
    vecs[4] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{3'b010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[6] = '{3'b010, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
    vecs[7] = '{3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[8] = '{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[9] = '{3'b011, 32'hFFFFFFFF, 32'h0000000A, 32'h00000005, 32'h19999999};

    reset = 1'b0; start = 1'b0; we = 1'b0; op = '0; A = '0; B = '0; sel_hi = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    chk("reset out", out, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle busy", {31'b0, busy}, 32'd0);

    // Table-driven arithmetic
    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].op[1] ? 10 : 5,
             vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i), 1'b0);

    // Divide by zero leaves HI/LO alone
    mt(3'b100, 32'h1234);
    mt(3'b101, 32'h5678);
    run_op(3'b010, 32'h00000064, 32'h0, 10, 32'h1234, 32'h5678, "div0", 1'b0);
    run_op(3'b011, 32'h00000064, 32'h0, 10, 32'h1234, 32'h5678, "divu0", 1'b0);

    // start/we injected while busy must not disturb a mult
    run_op(3'b000, 32'h00000010, 32'hFFFFFFFF, 5, 32'hFFFFFFFF, 32'hFFFFFFF0, "inject", 1'b1);
    @(negedge clk);
    chk("inject busy after", {31'b0, busy}, 32'd0);
    chk("inject HI stable", HI, 32'hFFFFFFFF);

    // Start with an out-of-range op is ignored
    @(negedge clk);
    start = 1'b1; op = 3'b111; A = 32'h55; B = 32'h3;
    @(negedge clk);
    start = 1'b0;
    chk("nop busy", {31'b0, busy}, 32'd0);
    chk("nop HI", HI, hi_m);
    chk("nop LO", LO, lo_m);

    // out mux in IDLE
    sel_hi = 1'b1; #1 chk("out HI", out, hi_m);
    sel_hi = 1'b0; #1 chk("out LO", out, lo_m);

    // Asynchronous reset mid-division
    @(negedge clk);
    start = 1'b1; op = 3'b010; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre-reset busy", {31'b0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async busy", {31'b0, busy}, 32'd0);
    chk("async HI", HI, 32'd0);
    chk("async LO", LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("post-reset busy", {31'b0, busy}, 32'd0);
    chk("post-reset HI", HI, 32'd0);
    chk("post-reset LO", LO, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
